fetch_unit: RTL
===============

# fetch_unit

Instruction fetch sequencer sitting between the address register file (ARF) and the decoder. It reads PC through ARF port A, fetches two 8-bit bytes from memory over a req/ack handshake, and increments PC after each byte using the ARF increment function. It presents the assembled 16-bit instruction to the decoder under a valid/ready handshake.

## Interface
- `MEM_WAIT_MAX`, default 15: number of cycles without `mem_ack` before a fetch faults (timeout build only).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level enable; while high, fetch runs continuously.
- `flush`  in  1  synchronous abort, e.g. on a taken branch.
- `pc`  in  8  ARF `out_a`.
- `arf_out_a_sel`  out  2  ARF port-A select; constant 2'b11 (PC).
- `arf_funsel`  out  2  ARF function: 00 clear, 01 load, 10 dec, 11 inc.
- `arf_r_sel`  out  4  ARF enables: bit3 AR, bit2 SP, bit1 PCPrev, bit0 PC.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  8  read address; equals `pc` whenever `mem_req` is high.
- `mem_ack`  in  1  read data valid this cycle.
- `mem_rdata`  in  8  read data.
- `ir`  out  16  assembled instruction.
- `ir_valid`  out  1  `ir` holds a complete instruction.
- `ir_ready`  in  1  decoder accepts `ir`.
- `fault`  out  1  memory timeout occurred; sticky.

## Operation
- FSM states: IDLE, REQ_LO, INC_LO, REQ_HI, INC_HI, HOLD, FAULT.
- IDLE: `start`=1 -> REQ_LO.
- REQ_LO / REQ_HI:
  - Drive `mem_req`=1.
  - On `mem_ack`, capture `mem_rdata` into `ir[7:0]` (REQ_LO) or `ir[15:8]` (REQ_HI), then go to INC_LO or INC_HI.
- INC_LO / INC_HI:
  - Drive `arf_funsel`=11 and `arf_r_sel`=0001 for exactly one cycle.
  - Next state is REQ_HI or HOLD respectively.
- HOLD:
  - Drive `ir_valid`=1; `ir` is stable.
  - On `ir_valid & ir_ready`: go to REQ_LO if `start`=1, else IDLE.
- Outside INC states, `arf_r_sel`=0000 and `arf_funsel`=00, so the ARF is untouched.
- `flush` (any state except FAULT):
  - Next state is IDLE and `ir_valid` drops.
  - `arf_r_sel` is forced to 0000 in the flush cycle, so no PC increment occurs.
  - A `mem_ack` arriving in the flush cycle is discarded.
  - Memory must tolerate `mem_req` dropping without ack.
- `ir` is not cleared by flush; it is only meaningful while `ir_valid`=1.
- `start` falling mid-fetch does not abort; the current instruction completes to HOLD.

## Timing
- Reset values: state IDLE, `ir`=0, `ir_valid`=0, `mem_req`=0, `fault`=0, `arf_r_sel`=0000, `arf_funsel`=00, `arf_out_a_sel`=11.
- All outputs are decoded from registered state, except:
  - `arf_r_sel` gating by `flush`;
  - `mem_addr`, which is `pc` passed through.
- `mem_req` stays high from entry to REQ_x up to and including the `mem_ack` cycle; it is low on the following cycle (INC_x).
- `mem_ack` while `mem_req`=0 is ignored.
- Minimum latency with zero-wait memory (ack in the first REQ cycle), from leaving IDLE to `ir_valid`: 4 cycles (REQ_LO, INC_LO, REQ_HI, INC_HI), then HOLD.
- Back-to-back fetch: 5 cycles per instruction with `ir_ready` held high.
- PC advances by 2 per instruction. At 8'hFF it wraps to 8'h00; the ARF handles the wrap.
- Reset asserted mid-operation takes effect immediately (asynchronous); any partial fetch is lost.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A wait counter clears on REQ_x entry and counts cycles with `mem_req`=1 and `mem_ack`=0.
  - When the count reaches `MEM_WAIT_MAX`, next state is FAULT and `fault`=1.
  - FAULT drives `mem_req`=0, ignores `start` and `flush`, and exits only on `rst_n`.
  - If ack and timeout occur in the same cycle, ack wins.
- `FETCH_TIMEOUT_EN` undefined: no counter, `fault` tied 0, REQ_x waits indefinitely.

## Structure
- Package `fetch_pkg` holds:
  - the state enum;
  - ARF constants `FS_CLEAR`=00, `FS_LOAD`=01, `FS_DEC`=10, `FS_INC`=11;
  - `RSEL_PC`=4'b0001, `RSEL_NONE`=4'b0000, `OSEL_PC`=2'b11.
- One sub-module, `fetch_wait_ctr` (clear/enable/terminal-count), instantiated only under `FETCH_TIMEOUT_EN`.
- The bench instantiates `fetch_unit` together with the real ARF and a behavioural memory with programmable ack delay.

## Test plan
- ARF cleared (PC=00), mem[00]=34, mem[01]=12, zero-wait memory, `start`=1, `ir_ready`=0 -> `ir_valid` after 4 cycles, `ir`=16'h1234, PC=02, `ir` held stable.
- Back-to-back with `ir_ready`=1 and mem[02..05]=AA,BB,CC,DD -> instructions BBAA then DDCC, 5 cycles apart; PC ends at 06.
- PC loaded to FE, mem[FE]=01, mem[FF]=02 -> `ir`=0201, PC wraps to 00.
- `flush` asserted during INC_LO -> exactly one cycle with `arf_r_sel`=0000, PC unchanged, next state IDLE, `ir_valid`=0.
- `FETCH_TIMEOUT_EN`, `MEM_WAIT_MAX`=15, memory never acks -> `fault`=1 after 15 request cycles, `mem_req`=0, state held until `rst_n` pulse, then all outputs at reset values.
- Ack delay of 3 cycles and random `ir_ready` over 20 instructions -> `mem_addr` stable while requesting, no lost or duplicated instruction, PC = 2 × instructions accepted.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and ARF control constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_LO,
    ST_INC_LO,
    ST_REQ_HI,
    ST_INC_HI,
    ST_HOLD,
    ST_FAULT
  } fetch_state_e;

  // ARF function select
  localparam logic [1:0] FS_CLEAR = 2'b00;
  localparam logic [1:0] FS_LOAD  = 2'b01;
  localparam logic [1:0] FS_DEC   = 2'b10;
  localparam logic [1:0] FS_INC   = 2'b11;

  // ARF register enables {AR, SP, PCPrev, PC} and port-A select
  localparam logic [3:0] RSEL_PC   = 4'b0001;
  localparam logic [3:0] RSEL_NONE = 4'b0000;
  localparam logic [1:0] OSEL_PC   = 2'b11;

  function automatic logic is_req(input fetch_state_e s);
    return (s == ST_REQ_LO) || (s == ST_REQ_HI);
  endfunction

  function automatic logic is_inc(input fetch_state_e s);
    return (s == ST_INC_LO) || (s == ST_INC_HI);
  endfunction

endpackage

// File: rtl/fetch_wait_ctr.sv
// fetch_wait_ctr: memory wait counter with clear, enable and terminal count.
// tc is raised during the MAX-th enabled cycle since the last clear.
module fetch_wait_ctr #(
  parameter int unsigned MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = (MAX < 2) ? 1 : $clog2(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == W'(MAX - 1));

  // Next count: held at zero while cleared, saturates at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !tc)
      cnt_d = cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: two-byte instruction fetch sequencer between ARF and decoder.
// Optional memory timeout with sticky fault: define FETCH_TIMEOUT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [7:0]  pc,
  output logic [1:0]  arf_out_a_sel,
  output logic [1:0]  arf_funsel,
  output logic [3:0]  arf_r_sel,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        fault
);

  fetch_state_e state_q, state_d;
  logic [15:0]  ir_q, ir_d;
  logic         ir_valid_q, ir_valid_d;
  logic         mem_req_q, mem_req_d;
  logic         inc_q, inc_d;
  logic [1:0]   arf_funsel_q, arf_funsel_d;
  logic         timeout;

`ifdef FETCH_TIMEOUT_EN
  logic fault_q, fault_d;

  // Counter sits at zero outside request phases, so every REQ entry starts from 0.
  fetch_wait_ctr #(
    .MAX (MEM_WAIT_MAX)
  ) u_wait_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~mem_req_q),
    .en    (mem_req_q & ~mem_ack),
    .tc    (timeout)
  );

  assign fault = fault_q;
`else
  logic unused_cfg;

  assign timeout    = 1'b0;
  assign fault      = 1'b0;
  assign unused_cfg = (MEM_WAIT_MAX == 0);
`endif

  assign arf_out_a_sel = OSEL_PC;
  assign mem_addr      = pc;
  assign mem_req       = mem_req_q;
  assign ir            = ir_q;
  assign ir_valid      = ir_valid_q;
  assign arf_funsel    = arf_funsel_q;
  // A flush in the increment cycle must not touch PC.
  assign arf_r_sel     = (inc_q && !flush) ? RSEL_PC : RSEL_NONE;

  // Next state, byte capture and registered output decode.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_REQ_LO;
      ST_REQ_LO: begin
        if (mem_ack) begin
          ir_d[7:0] = mem_rdata;
          state_d   = ST_INC_LO;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_INC_LO: state_d = ST_REQ_HI;
      ST_REQ_HI: begin
        if (mem_ack) begin
          ir_d[15:8] = mem_rdata;
          state_d    = ST_INC_HI;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_INC_HI: state_d = ST_HOLD;
      ST_HOLD:   if (ir_ready) state_d = start ? ST_REQ_LO : ST_IDLE;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase

    // Flush overrides everything except a fault; an ack in this cycle is dropped.
    if (flush && (state_q != ST_FAULT)) begin
      state_d = ST_IDLE;
      ir_d    = ir_q;
    end

    // Outputs are decoded from the next state so they register alongside it.
    mem_req_d    = is_req(state_d);
    inc_d        = is_inc(state_d);
    ir_valid_d   = (state_d == ST_HOLD);
    arf_funsel_d = inc_d ? FS_INC : FS_CLEAR;
`ifdef FETCH_TIMEOUT_EN
    fault_d      = (state_d == ST_FAULT);
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ir_q         <= '0;
      ir_valid_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      inc_q        <= 1'b0;
      arf_funsel_q <= FS_CLEAR;
`ifdef FETCH_TIMEOUT_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      mem_req_q    <= mem_req_d;
      inc_q        <= inc_d;
      arf_funsel_q <= arf_funsel_d;
`ifdef FETCH_TIMEOUT_EN
      fault_q      <= fault_d;
`endif
    end
  end

endmodule
